somador: RTL and testbench

- 16-bit signed two's-complement adder/subtractor with signed-overflow detection.
- Operation select: op=1 adds, op=0 subtracts (a - b).
- Result and overflow are registered: one clock of latency.
- Used as the arithmetic unit of the datapath; also serves as a standalone add/sub block.

---
 rtl/somador.sv | 46 ++++
 tb/tb_somador.sv | 131 +++++++++++++
 2 files changed

// File: rtl/somador.sv
// somador: registered signed adder/subtractor with two's-complement overflow.
// op=1 computes a + b, op=0 computes a - b as a + ~b + 1 through one
// ripple-carry chain. Result and overflow appear one clock after capture.
module somador #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             overflow,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             ovf_next;

  // Ripple-carry chain: conditionally inverted b, carry-in ~op for subtract.
  always_comb begin
    b_eff    = b ^ {WIDTH{~op}};
    carry    = '0;
    sum      = '0;
    carry[0] = ~op;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a[i] & b_eff[i]) | (a[i] & carry[i]) | (b_eff[i] & carry[i]);
    end
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    ovf_next = carry[WIDTH] ^ carry[WIDTH-1];
  end

  // Output register; reset wins and discards the operands on that edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      result   <= sum;
      overflow <= ovf_next;
    end
  end

endmodule

// File: tb/tb_somador.sv
// tb_somador: scoreboard bench for somador. Expected values are derived
// from integer arithmetic, pushed when operands are driven and popped
// once the registered outputs are available after the capturing edge.
module tb_somador;

  logic        clock;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic        op;
  logic        overflow;
  logic [15:0] result;

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  somador #(.WIDTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .op       (op),
    .overflow (overflow),
    .result   (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input int x, input int y,
                                 input logic o, input logic r);
    exp_t m;
    int   s;
    s     = o ? (x + y) : (x - y);
    m.tag = tag;
    if (r) begin
      m.res = 16'd0;
      m.ovf = 1'b0;
    end else begin
      m.res = s[15:0];
      m.ovf = (s > 32767) || (s < -32768);
    end
    return m;
  endfunction

  // Drive one vector on the falling edge, let the next rising edge capture
  // it, then compare the registered outputs shortly after that edge.
  task automatic apply(input string tag, input int x, input int y,
                       input logic o, input logic r);
    exp_t e;
    @(negedge clock);
    reset = r;
    a     = x[15:0];
    b     = y[15:0];
    op    = o;
    sb.push_back(model(tag, x, y, o, r));
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_res"}, {16'd0, result}, {16'd0, e.res});
      check({e.tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    a       = 16'h1234;
    b       = 16'hBEEF;
    op      = 1'b1;

    // Reset with arbitrary operands must yield zeros.
    apply("rst0", 1234, -555, 1'b1, 1'b1);
    apply("rst1", -32768, 32767, 1'b0, 1'b1);

    // Directed vectors, issued back to back.
    apply("add_35_72",       35,      72,   1'b1, 1'b0);
    apply("add_ovf_pos",     32512,   256,  1'b1, 1'b0);
    apply("add_neg",         -21846,  -7680, 1'b1, 1'b0);
    apply("sub_neg",         -256,    256,  1'b0, 1'b0);
    apply("sub_pos",         502,     124,  1'b0, 1'b0);
    apply("sub_ovf",         -28576,  25604, 1'b0, 1'b0);
    apply("min_minus_1",     -32768,  1,    1'b0, 1'b0);
    apply("max_plus_1",      32767,   1,    1'b1, 1'b0);
    apply("zero_minus_min",  0,       -32768, 1'b0, 1'b0);
    apply("min_plus_min",    -32768,  -32768, 1'b1, 1'b0);
    apply("x_minus_x",       -12345,  -12345, 1'b0, 1'b0);
    apply("max_minus_max",   32767,   32767, 1'b0, 1'b0);
    apply("neg1_plus_1",     -1,      1,    1'b1, 1'b0);

    // Back-to-back random stream, alternating op, no idle cycles.
    for (int i = 0; i < 60; i++) begin
      int x;
      int y;
      x = int'($urandom_range(0, 65535)) - 32768;
      y = int'($urandom_range(0, 65535)) - 32768;
      if (i % 10 == 3) x = 32767;
      if (i % 10 == 7) y = -32768;
      apply("stream", x, y, i[0], 1'b0);
    end

    // Mid-stream reset discards its operands; the next vector computes.
    apply("pre_rst",  1000, 2000, 1'b1, 1'b0);
    apply("mid_rst",  100,  200,  1'b1, 1'b1);
    apply("post_rst", 100,  200,  1'b1, 1'b0);
    apply("post_sub", 100,  200,  1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
